store_unit: RTL and testbench
=============================

# store_unit

Store execution unit for the Green datapath and the write-side counterpart of the load path. It takes a decoded store instruction, selects register A or B as the source, and writes either a full 16-bit word or one byte lane to data memory. Byte stores use a read-modify-write sequence over a request/acknowledge memory port. The unit sits between instruction decode and the data-memory arbiter, and reports completion to the sequencer with a one-cycle `done` pulse.

## Interface
- `ACK_TIMEOUT`, default 16: maximum number of cycles a memory request waits for `mem_ack`; 0 disables the timeout.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  store request; sampled only when `busy`=0.
- `ins`  in  16  store instruction, captured on accept:
  - [11]: source select, 0=A, 1=B.
  - [10]: width, 0=word, 1=byte.
  - [9]: lane, 0=low byte, 1=high byte.
  - [7:0]: address.
- `A_in`, `B_in`  in  16 each  register operands, captured on accept.
- `busy`  out  1  high from the cycle after accept until `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, on timeout.
- `mem_addr`  out  8  memory address; equals captured `ins[7:0]`.
- `mem_re`  out  1  read request; held until ack.
- `mem_we`  out  1  write request; held until ack.
- `mem_wdata`  out  16  write data; stable while `mem_we`=1.
- `mem_rdata`  in  16  read data; valid in the cycle where `mem_re`=1 and `mem_ack`=1.
- `mem_ack`  in  1  memory acknowledge.

## Operation
- **States**
  - IDLE: `start`=1 captures `ins`, `A_in`, `B_in`. The unit then goes to WRITE if the store is a word store, or to READ if it is a byte store.
  - READ: asserts `mem_re`. On `mem_ack`, latches the merged word and goes to WRITE.
  - WRITE: asserts `mem_we`. On `mem_ack`, goes to DONE.
  - DONE: `done`=1 and `busy`=0, then returns to IDLE. A new `start` is accepted from the DONE cycle onward.
- **Source**: src = `ins[11]` ? B : A.
- **Write data**
  - Word store: `mem_wdata` = src.
  - Byte store, low lane: `mem_wdata` = {rdata[15:8], src[7:0]}.
  - Byte store, high lane: `mem_wdata` = {src[7:0], rdata[7:0]}.
  - The source byte is always src[7:0].
- **Timeout**
  - A counter clears on entry to READ or WRITE and increments each cycle without ack.
  - When it reaches `ACK_TIMEOUT` without ack, the request drops, `done` and `err` pulse together in the next cycle, and the unit returns to IDLE.
  - Memory is not written on a timeout in READ.
  - If ack arrives in the same cycle the counter expires, the ack wins.
- **Ignored inputs**
  - `start` while `busy`=1 is ignored; it is not queued.
  - `mem_ack` in IDLE or DONE is ignored.
- **Reset**
  - The following clear immediately: `busy`, `done`, `err`, `mem_re`, `mem_we`, `mem_addr`=0, `mem_wdata`=0, and the state returns to IDLE.
  - A reset mid-operation abandons the transaction and issues no write.

## Timing
- All outputs are registered.
- Word store, accepted at cycle N with zero-wait ack: `mem_we`=1 at N+1, `done` at N+2.
- Byte store, accepted at cycle N with zero-wait ack: `mem_re` at N+1, `mem_we` at N+2, `done` at N+3.
- Each wait cycle on ack adds one cycle to the corresponding phase.
- Timeout: `done`+`err` occur `ACK_TIMEOUT`+1 cycles after request assertion.
- `mem_addr` is stable from the first request cycle through the final ack.

## Structure
- **Shared package `green_pkg`**
  - Constants for instruction bit positions: `INS_SRC_BIT`=11, `INS_BYTE_BIT`=10, `INS_HI_BIT`=9.
  - Address field width: 8.
  - State enum: IDLE, READ, WRITE, DONE.
- **Sub-module `store_merge`**: combinational byte-lane merge.
  - Inputs: src, rdata, byte, hi.
  - Output: wdata.
  - Reused by any future partial-write path.

## Test plan
- **Word store**: A=0x1234, ins=0x0042, zero-wait ack. Required: `mem_we` at N+1, addr=0x42, wdata=0x1234, `done` at N+2, `err`=0.
- **Low-byte store from B**: B=0x00AB, ins=0x0C10, memory returns 0x5566. Required: a read, then a write of 0x55AB to 0x10, `done` at N+3.
- **High-byte store**: A=0x00CD, ins=0x0610, memory returns 0x5566, with 3 wait cycles on each ack. Required: wdata=0xCD66, `done` at N+9.
- **Timeout**: `ACK_TIMEOUT`=4 and no ack. Required: `mem_we` high for 4 cycles then low, `done`=`err`=1 one cycle later; a subsequent `start` is accepted normally.
- **Busy and ack-versus-timeout collision**:
  - `start` pulsed while busy: ignored, exactly one write occurs.
  - Ack on the expiry cycle: `err`=0.
- **Reset mid-byte-store during READ wait**: all outputs 0 immediately and no `mem_we` is ever seen. A store issued after reset release completes normally.

Source files
------------

// File: rtl/green_pkg.sv
// Shared Green datapath definitions: instruction field positions, widths and store FSM states.
// Purely declarative. It has no latency and no flow control.
package green_pkg;

  localparam int INS_SRC_BIT  = 11;
  localparam int INS_BYTE_BIT = 10;
  localparam int INS_HI_BIT   = 9;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/store_merge.sv
// Byte-lane merge of a source byte into a read-back word. Word stores pass src through unchanged.
// Combinational, so it has zero latency and no flow control.
module store_merge
  import green_pkg::*;
(
  input  logic [DATA_W-1:0] src,
  input  logic [DATA_W-1:0] rdata,
  input  logic              byte_op,
  input  logic              hi,
  output logic [DATA_W-1:0] wdata
);

  always_comb begin
    wdata = src;
    if (byte_op) begin
      // The source byte always comes from src[7:0], whichever lane it lands in.
      if (hi) wdata = {src[7:0], rdata[7:0]};
      else    wdata = {rdata[15:8], src[7:0]};
    end
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: a word store takes 2 cycles and a byte store takes 3 (read-modify-write), plus one cycle per ack wait.
// Requests are held until mem_ack or until the timeout expires. start is ignored while busy.
module store_unit
  import green_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       ins,
  input  logic [DATA_W-1:0] A_in,
  input  logic [DATA_W-1:0] B_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_t            state;
  logic [DATA_W-1:0] src_q;
  logic              byte_q;
  logic              hi_q;
  logic [31:0]       cnt;
  logic              expired;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] src_in;
  logic              timeout_hit;
  logic              unused_ins;

  assign src_in      = ins[INS_SRC_BIT] ? B_in : A_in;
  assign unused_ins  = ^{ins[15:12], ins[8]};
  // The request drops after its last allowed cycle, so it is seen for exactly ACK_TIMEOUT cycles.
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt == ACK_TIMEOUT - 32'd1);

  store_merge u_merge (
    .src     (src_q),
    .rdata   (mem_rdata),
    .byte_op (byte_q),
    .hi      (hi_q),
    .wdata   (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      src_q     <= '0;
      byte_q    <= 1'b0;
      hi_q      <= 1'b0;
      cnt       <= '0;
      expired   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            src_q    <= src_in;
            byte_q   <= ins[INS_BYTE_BIT];
            hi_q     <= ins[INS_HI_BIT];
            mem_addr <= ins[ADDR_W-1:0];
            busy     <= 1'b1;
            cnt      <= '0;
            expired  <= 1'b0;
            if (ins[INS_BYTE_BIT]) begin
              state  <= READ;
              mem_re <= 1'b1;
            end else begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= src_in;
            end
          end
        end
        READ, WRITE: begin
          if (expired) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            expired <= 1'b0;
          end else if (mem_ack) begin
            cnt <= '0;
            if (state == READ) begin
              mem_re    <= 1'b0;
              mem_we    <= 1'b1;
              mem_wdata <= merged;
              state     <= WRITE;
            end else begin
              mem_we <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end
          end else if (timeout_hit) begin
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            expired <= 1'b1;
          end else if (ACK_TIMEOUT != 0) begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: word, byte-lane, wait-state, timeout, busy, collision and reset cases.
module tb_store_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] ins;
  logic [15:0] A_in;
  logic [15:0] B_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;
  int we_cycles = 0;
  int wr_hs = 0;
  int we_base;
  int hs_base;

  store_unit #(.ACK_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ins       (ins),
    .A_in      (A_in),
    .B_in      (B_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) we_cycles++;
    if (mem_we && mem_ack) wr_hs++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ins = '0; A_in = '0; B_in = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_re", 32'(mem_re), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    rst_n = 1'b1;
    tick();

    // Word store, zero-wait ack
    hs_base = wr_hs;
    A_in = 16'h1234; B_in = 16'hFFFF; ins = 16'h0042; start = 1'b1;
    tick();                                   // N+1
    start = 1'b0;
    chk("w_we", 32'(mem_we), 1);
    chk("w_re", 32'(mem_re), 0);
    chk("w_addr", 32'(mem_addr), 'h42);
    chk("w_wdata", 32'(mem_wdata), 'h1234);
    chk("w_busy", 32'(busy), 1);
    chk("w_done_early", 32'(done), 0);
    mem_ack = 1'b1;
    tick();                                   // N+2
    mem_ack = 1'b0;
    chk("w_done", 32'(done), 1);
    chk("w_err", 32'(err), 0);
    chk("w_we_off", 32'(mem_we), 0);
    chk("w_busy_done", 32'(busy), 0);
    tick();
    chk("w_done_pulse", 32'(done), 0);
    chk("w_writes", 32'(wr_hs - hs_base), 1);

    // Low-byte store from B
    B_in = 16'h00AB; A_in = 16'h7777; ins = 16'h0C10; start = 1'b1;
    tick();                                   // N+1
    start = 1'b0;
    chk("lb_re", 32'(mem_re), 1);
    chk("lb_we", 32'(mem_we), 0);
    chk("lb_addr", 32'(mem_addr), 'h10);
    mem_rdata = 16'h5566; mem_ack = 1'b1;
    tick();                                   // N+2
    mem_rdata = 16'h0000;
    chk("lb_re_off", 32'(mem_re), 0);
    chk("lb_we_on", 32'(mem_we), 1);
    chk("lb_wdata", 32'(mem_wdata), 'h55AB);
    chk("lb_addr2", 32'(mem_addr), 'h10);
    chk("lb_done_early", 32'(done), 0);
    tick();                                   // N+3
    mem_ack = 1'b0;
    chk("lb_done", 32'(done), 1);
    chk("lb_err", 32'(err), 0);
    tick();

    // High-byte store, 3 wait cycles per phase; the acks land on the timeout expiry cycle
    A_in = 16'h00CD; B_in = 16'h9999; ins = 16'h0610; start = 1'b1;
    tick();                                   // N+1
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hb_re_wait", 32'(mem_re), 1);
      tick();
    end                                       // N+4
    chk("hb_re_last", 32'(mem_re), 1);
    mem_rdata = 16'h5566; mem_ack = 1'b1;
    tick();                                   // N+5
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    chk("hb_we", 32'(mem_we), 1);
    chk("hb_wdata", 32'(mem_wdata), 'hCD66);
    tick(); tick(); tick();                   // N+8
    chk("hb_we_last", 32'(mem_we), 1);
    chk("hb_done_early", 32'(done), 0);
    mem_ack = 1'b1;
    tick();                                   // N+9
    mem_ack = 1'b0;
    chk("hb_done", 32'(done), 1);
    chk("hb_err_collide", 32'(err), 0);
    tick();

    // Write timeout: no ack
    hs_base = wr_hs;
    A_in = 16'hBEEF; ins = 16'h0042; start = 1'b1;
    tick();                                   // R
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_we_high", 32'(mem_we), 1);
      tick();
    end                                       // R+4
    chk("to_we_low", 32'(mem_we), 0);
    chk("to_done_early", 32'(done), 0);
    chk("to_busy", 32'(busy), 1);
    tick();                                   // R+5
    chk("to_done", 32'(done), 1);
    chk("to_err", 32'(err), 1);
    chk("to_busy_off", 32'(busy), 0);
    tick();
    chk("to_err_pulse", 32'(err), 0);
    chk("to_no_write", 32'(wr_hs - hs_base), 0);
    A_in = 16'h0F0F; ins = 16'h0021; start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_next_we", 32'(mem_we), 1);
    chk("to_next_wdata", 32'(mem_wdata), 'h0F0F);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("to_next_done", 32'(done), 1);
    chk("to_next_err", 32'(err), 0);
    tick();

    // Ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_busy", 32'(busy), 0);
    chk("idle_ack_done", 32'(done), 0);

    // start while busy is ignored
    hs_base = wr_hs;
    A_in = 16'h1111; ins = 16'h0050; start = 1'b1;
    tick();                                   // R
    A_in = 16'h2222; ins = 16'h0060;
    tick();                                   // R+1
    start = 1'b0;
    chk("bz_addr", 32'(mem_addr), 'h50);
    chk("bz_wdata", 32'(mem_wdata), 'h1111);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("bz_done", 32'(done), 1);
    tick(); tick();
    chk("bz_no_requeue", 32'(mem_we), 0);
    chk("bz_idle", 32'(busy), 0);
    chk("bz_one_write", 32'(wr_hs - hs_base), 1);

    // Reset during the READ wait of a byte store
    we_base = we_cycles;
    A_in = 16'h00EE; ins = 16'h0410; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rr_re", 32'(mem_re), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rr_re0", 32'(mem_re), 0);
    chk("rr_we0", 32'(mem_we), 0);
    chk("rr_busy0", 32'(busy), 0);
    chk("rr_addr0", 32'(mem_addr), 0);
    chk("rr_wdata0", 32'(mem_wdata), 0);
    chk("rr_done0", 32'(done), 0);
    mem_ack = 1'b1; mem_rdata = 16'h5566;
    tick(); tick();
    mem_ack = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    chk("rr_no_we", 32'(we_cycles - we_base), 0);
    A_in = 16'hA5A5; ins = 16'h0033; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rr_post_we", 32'(mem_we), 1);
    chk("rr_post_addr", 32'(mem_addr), 'h33);
    chk("rr_post_wdata", 32'(mem_wdata), 'hA5A5);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rr_post_done", 32'(done), 1);
    chk("rr_post_err", 32'(err), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
